// File: rtl/ext_bus_bridge_pkg.sv
// Shared types for the multi-channel Avalon-MM to external-bus bridge.
package ext_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ext_bus_bridge_timer.sv
// Ack-wait timer: counts enabled cycles, saturates at TIMEOUT, flags expiry (TIMEOUT=0 never expires).
module ext_bus_bridge_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]  LIMIT  = TW'(TIMEOUT);
  localparam bit             ACTIVE = (TIMEOUT != 0);

  logic [TW-1:0] count_q;
  logic          at_limit;

  assign at_limit = (count_q == LIMIT);
  assign expired  = ACTIVE && at_limit;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !at_limit) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ext_bus_bridge_mc.sv
// N-channel Avalon-MM slave bridge: one external access at a time, ack timeout, irq aggregation.
module ext_bus_bridge_mc
  import ext_bus_bridge_pkg::*;
#(
  parameter int                 CHANNELS     = 2,
  parameter int                 ADDR_W       = 16,
  parameter int                 DATA_W       = 16,
  parameter int                 TIMEOUT      = 255,
  parameter logic [DATA_W-1:0]  TIMEOUT_DATA = '1,
  localparam int                BE_W         = DATA_W / 8,
  localparam int                CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic [CH_W+ADDR_W-1:0]       avs_address,
  input  logic                         avs_read,
  input  logic                         avs_write,
  input  logic [BE_W-1:0]              avs_byteenable,
  input  logic [DATA_W-1:0]            avs_writedata,
  output logic [DATA_W-1:0]            avs_readdata,
  output logic                         avs_waitrequest,
  output logic [1:0]                   avs_response,
  output logic [CHANNELS*ADDR_W-1:0]   ext_address,
  output logic [CHANNELS-1:0]          ext_bus_enable,
  output logic [CHANNELS*BE_W-1:0]     ext_byte_enable,
  output logic [CHANNELS-1:0]          ext_rw,
  output logic [CHANNELS*DATA_W-1:0]   ext_write_data,
  input  logic [CHANNELS*DATA_W-1:0]   ext_read_data,
  input  logic [CHANNELS-1:0]          ext_acknowledge,
  input  logic [CHANNELS-1:0]          ext_irq,
  output logic [CHANNELS-1:0]          irq_status,
  output logic                         irq,
  output logic [CHANNELS-1:0]          err_sticky,
  input  logic                         err_clear
);

  // One bit per encodable channel number; unpopulated channel numbers decode as errors.
  localparam int                  CH_SPAN  = 1 << CH_W;
  localparam logic [CH_SPAN-1:0]  CH_VALID = CH_SPAN'((1 << CHANNELS) - 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rd_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;

  logic                req;
  logic [CH_W-1:0]     req_ch;
  logic                dec_err;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;
  logic                tmr_expired;
  logic                timeout_hit;
  logic [CHANNELS-1:0] err_set;

  assign req     = avs_read | avs_write;
  assign req_ch  = avs_address[CH_W+ADDR_W-1:ADDR_W];
  assign dec_err = ~CH_VALID[req_ch];

  ext_bus_bridge_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .clear   (state_q != BUS),
    .enable  (state_q == BUS),
    .expired (tmr_expired)
  );

  // Ack has priority over expiry in the same cycle.
  assign timeout_hit = (state_q == BUS) && !sel_ack && tmr_expired;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    err_set   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_q == CH_W'(c)) begin
        sel_ack    = ext_acknowledge[c];
        sel_rdata  = ext_read_data[c*DATA_W +: DATA_W];
        err_set[c] = timeout_hit;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = dec_err ? DONE : BUS;
      BUS:     if (sel_ack || tmr_expired) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ch_q    <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            ch_q    <= req_ch;
            addr_q  <= avs_address[ADDR_W-1:0];
            be_q    <= avs_byteenable;
            wdata_q <= avs_writedata;
            rd_q    <= ~avs_write;
            if (dec_err) begin
              rdata_q <= '0;
              resp_q  <= RESP_DECERR;
            end
          end
        end
        BUS: begin
          if (sel_ack) begin
            rdata_q <= rd_q ? sel_rdata : '0;
            resp_q  <= RESP_OKAY;
          end else if (tmr_expired) begin
            rdata_q <= rd_q ? TIMEOUT_DATA : '0;
            resp_q  <= RESP_SLVERR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      err_sticky <= '0;
      irq_status <= '0;
    end else begin
      err_sticky <= (err_clear ? '0 : err_sticky) | err_set;
      irq_status <= ext_irq;
    end
  end

  assign irq             = |irq_status;
  assign avs_waitrequest = (state_q != DONE);
  assign avs_readdata    = rdata_q;
  assign avs_response    = resp_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic sel;
    assign sel                                = (state_q == BUS) && (ch_q == CH_W'(c));
    assign ext_bus_enable[c]                  = sel;
    assign ext_rw[c]                          = sel & rd_q;
    assign ext_address[c*ADDR_W +: ADDR_W]    = sel ? addr_q  : '0;
    assign ext_byte_enable[c*BE_W +: BE_W]    = sel ? be_q    : '0;
    assign ext_write_data[c*DATA_W +: DATA_W] = sel ? wdata_q : '0;
  end

endmodule
